// File: rtl/riscv_dmem_resp_pkg.sv
// Shared types and helpers for the data-memory responder.
package riscv_pkg;

    // Atomic memory operation selector
    typedef enum logic [3:0] {
        AMO_SWAP = 4'd0,
        AMO_ADD  = 4'd1,
        AMO_XOR  = 4'd2,
        AMO_AND  = 4'd3,
        AMO_OR   = 4'd4,
        AMO_MIN  = 4'd5,
        AMO_MAX  = 4'd6,
        AMO_MINU = 4'd7,
        AMO_MAXU = 4'd8
    } amo_op_e;

    // Access width
    typedef enum logic [1:0] {
        SIZE_B = 2'b00,
        SIZE_H = 2'b01,
        SIZE_W = 2'b10,
        SIZE_D = 2'b11
    } mem_size_e;

    // AMO sequencer states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        AMO_RD = 2'd1,
        AMO_WR = 2'd2
    } dmem_state_e;

    // True when the byte offset is a multiple of the access width
    function automatic logic isAligned(input logic [1:0] size, input logic [2:0] offset);
        case (size)
            2'b00:   isAligned = 1'b1;
            2'b01:   isAligned = ~offset[0];
            2'b10:   isAligned = (offset[1:0] == 2'b00);
            default: isAligned = (offset == 3'b000);
        endcase
    endfunction

    // Byte-enable pattern for an access of the given width at offset 0
    function automatic logic [7:0] byteMask(input logic [1:0] size);
        case (size)
            2'b00:   byteMask = 8'h01;
            2'b01:   byteMask = 8'h03;
            2'b10:   byteMask = 8'h0F;
            default: byteMask = 8'hFF;
        endcase
    endfunction

endpackage

// File: rtl/riscv_dmem_resp_if.sv
// Request/response bundle between the LSU and the data-memory responder.
interface riscv_dmem_resp_if;

    logic        i_riscv_dmem_memread_en;
    logic        i_riscv_dmem_memwrite_en;
    logic        i_riscv_dmem_amo_en;
    logic [3:0]  i_riscv_dmem_amo_op;
    logic [1:0]  i_riscv_dmem_size;
    logic [63:0] i_riscv_dmem_address;
    logic [63:0] i_riscv_dmem_wdata;
    logic [63:0] o_riscv_dmem_rdata;
    logic        o_riscv_dmem_rvalid;
    logic        o_riscv_dmem_stall;
    logic        o_riscv_dmem_fault;

    // LSU side drives requests and observes responses
    modport master (
        output i_riscv_dmem_memread_en, i_riscv_dmem_memwrite_en, i_riscv_dmem_amo_en,
               i_riscv_dmem_amo_op, i_riscv_dmem_size, i_riscv_dmem_address, i_riscv_dmem_wdata,
        input  o_riscv_dmem_rdata, o_riscv_dmem_rvalid, o_riscv_dmem_stall, o_riscv_dmem_fault
    );

    // Memory side services requests
    modport slave (
        input  i_riscv_dmem_memread_en, i_riscv_dmem_memwrite_en, i_riscv_dmem_amo_en,
               i_riscv_dmem_amo_op, i_riscv_dmem_size, i_riscv_dmem_address, i_riscv_dmem_wdata,
        output o_riscv_dmem_rdata, o_riscv_dmem_rvalid, o_riscv_dmem_stall, o_riscv_dmem_fault
    );

endinterface

// File: rtl/riscv_dmem_resp_amo_alu.sv
// Combinational AMO arithmetic. Word operations only produce a meaningful
// low 32 bits; the caller places them back into the selected lane.
module riscv_amo_alu
    import riscv_pkg::*;
(
    input  logic [63:0] old_i,
    input  logic [63:0] operand_i,
    input  amo_op_e     op_i,
    input  logic        isWord_i,
    output logic [63:0] new_o
);

    logic [63:0] aS, bS, aU, bU;

    // Widen word operands both ways so one 64-bit compare/add serves both widths
    always_comb begin
        aS    = isWord_i ? {{32{old_i[31]}}, old_i[31:0]}         : old_i;
        bS    = isWord_i ? {{32{operand_i[31]}}, operand_i[31:0]} : operand_i;
        aU    = isWord_i ? {32'b0, old_i[31:0]}                   : old_i;
        bU    = isWord_i ? {32'b0, operand_i[31:0]}               : operand_i;
        new_o = bU;
        case (op_i)
            AMO_SWAP: new_o = bU;
            AMO_ADD:  new_o = aU + bU;
            AMO_XOR:  new_o = aU ^ bU;
            AMO_AND:  new_o = aU & bU;
            AMO_OR:   new_o = aU | bU;
            AMO_MIN:  new_o = ($signed(aS) < $signed(bS)) ? aS : bS;
            AMO_MAX:  new_o = ($signed(aS) > $signed(bS)) ? aS : bS;
            AMO_MINU: new_o = (aU < bU) ? aU : bU;
            AMO_MAXU: new_o = (aU > bU) ? aU : bU;
            default:  new_o = bU;
        endcase
    end

endmodule

// File: rtl/riscv_dmem_resp.sv
// Data-memory responder: byte-lane loads/stores on a doubleword array plus a
// three-state read-modify-write sequencer for AMOs that stalls the pipeline.
module riscv_dmem_resp
    import riscv_pkg::*;
#(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic             i_riscv_dmem_clk,
    input  logic             i_riscv_dmem_rst_n,
    riscv_dmem_resp_if.slave bus
);

    dmem_state_e       state_q, state_d;
    logic [63:0]       mem [DEPTH];

    logic [ADDR_W-1:0] reqIdx;
    logic [2:0]        reqOff;
    logic [1:0]        reqSize;
    logic              isAmoReq, isWrReq, isRdReq, anyReq, aligned;
    logic              amoAccept, wrAccept, rdAccept, faultReq, stallComb;

    logic [ADDR_W-1:0] amoIdx_q, amoIdx_d;
    logic              amoLane_q, amoLane_d;
    logic              amoIsWord_q, amoIsWord_d;
    amo_op_e           amoOp_q, amoOp_d;
    logic [63:0]       operand_q, operand_d;
    logic [63:0]       old_q, old_d;
    logic [63:0]       rdata_q, rdata_d;
    logic              rvalid_q, rvalid_d;
    logic              fault_q, fault_d;

    logic [63:0]       amoOldRaw, amoRet, aluOld, aluNew, amoWdata, rdShift, rdMask;
    logic [7:0]        amoBe;
    logic              memWe;
    logic [ADDR_W-1:0] memWIdx;
    logic [7:0]        memBe;
    logic [63:0]       memWdata;

    assign reqIdx  = bus.i_riscv_dmem_address[ADDR_W+2:3];
    assign reqOff  = bus.i_riscv_dmem_address[2:0];
    assign reqSize = bus.i_riscv_dmem_size;

    // AMO takes precedence over a plain write; a plain write beats a plain read
    assign isAmoReq  = bus.i_riscv_dmem_memread_en & bus.i_riscv_dmem_amo_en;
    assign isWrReq   = bus.i_riscv_dmem_memwrite_en & ~isAmoReq;
    assign isRdReq   = bus.i_riscv_dmem_memread_en & ~bus.i_riscv_dmem_amo_en
                       & ~bus.i_riscv_dmem_memwrite_en;
    assign anyReq    = bus.i_riscv_dmem_memread_en | bus.i_riscv_dmem_memwrite_en;
    assign aligned   = isAligned(reqSize, reqOff);

    assign amoAccept = (state_q == IDLE) & isAmoReq & aligned & reqSize[1];
    assign wrAccept  = (state_q == IDLE) & isWrReq & aligned;
    assign rdAccept  = (state_q == IDLE) & isRdReq & aligned;
    assign faultReq  = (state_q == IDLE) & anyReq & ~(aligned & (~isAmoReq | reqSize[1]));

    // Load path: shift the addressed lane down and clear bits above the width
    always_comb begin
        rdShift = mem[reqIdx] >> {reqOff, 3'b000};
        case (reqSize)
            2'b00:   rdMask = 64'h0000_0000_0000_00FF;
            2'b01:   rdMask = 64'h0000_0000_0000_FFFF;
            2'b10:   rdMask = 64'h0000_0000_FFFF_FFFF;
            default: rdMask = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
    end

    // AMO operand preparation: old lane for the ALU, sign-extended return value, write-back lane
    always_comb begin
        amoOldRaw = mem[amoIdx_q];
        if (amoIsWord_q) begin
            amoRet   = amoLane_q ? {{32{amoOldRaw[63]}}, amoOldRaw[63:32]}
                                 : {{32{amoOldRaw[31]}}, amoOldRaw[31:0]};
            aluOld   = {32'b0, amoLane_q ? old_q[63:32] : old_q[31:0]};
            amoWdata = {aluNew[31:0], aluNew[31:0]};
            amoBe    = amoLane_q ? 8'hF0 : 8'h0F;
        end else begin
            amoRet   = amoOldRaw;
            aluOld   = old_q;
            amoWdata = aluNew;
            amoBe    = 8'hFF;
        end
    end

    riscv_amo_alu uAmoAlu (
        .old_i     (aluOld),
        .operand_i (operand_q),
        .op_i      (amoOp_q),
        .isWord_i  (amoIsWord_q),
        .new_o     (aluNew)
    );

    // Array write port shared by stores and the AMO write-back; nothing lands while in reset
    always_comb begin
        memWe    = i_riscv_dmem_rst_n & (wrAccept | (state_q == AMO_WR));
        memWIdx  = reqIdx;
        memBe    = byteMask(reqSize) << reqOff;
        memWdata = bus.i_riscv_dmem_wdata << {reqOff, 3'b000};
        if (state_q == AMO_WR) begin
            memWIdx  = amoIdx_q;
            memBe    = amoBe;
            memWdata = amoWdata;
        end
    end

    // Behavioural doubleword array with per-byte write enables; contents are not reset
    always_ff @(posedge i_riscv_dmem_clk) begin
        if (memWe) begin
            for (int b = 0; b < 8; b++) begin
                if (memBe[b]) begin
                    mem[memWIdx][b*8 +: 8] <= memWdata[b*8 +: 8];
                end
            end
        end
    end

    // AMO sequencer next state and combinational stall
    always_comb begin
        state_d   = state_q;
        stallComb = 1'b0;
        case (state_q)
            IDLE: begin
                if (amoAccept) begin
                    state_d   = AMO_RD;
                    stallComb = 1'b1;
                end
            end
            AMO_RD: begin
                stallComb = 1'b1;
                state_d   = AMO_WR;
            end
            AMO_WR:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Sequencer state register
    always_ff @(posedge i_riscv_dmem_clk or negedge i_riscv_dmem_rst_n) begin
        if (!i_riscv_dmem_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next values for the AMO context and the registered response
    always_comb begin
        amoIdx_d    = amoIdx_q;
        amoLane_d   = amoLane_q;
        amoIsWord_d = amoIsWord_q;
        amoOp_d     = amoOp_q;
        operand_d   = operand_q;
        old_d       = old_q;
        rdata_d     = rdata_q;
        rvalid_d    = 1'b0;
        fault_d     = faultReq;
        if (amoAccept) begin
            amoIdx_d    = reqIdx;
            amoLane_d   = reqOff[2];
            amoIsWord_d = (reqSize == SIZE_W);
            amoOp_d     = amo_op_e'(bus.i_riscv_dmem_amo_op);
            operand_d   = bus.i_riscv_dmem_wdata;
        end
        if (rdAccept) begin
            rdata_d  = rdShift & rdMask;
            rvalid_d = 1'b1;
        end
        if (state_q == AMO_RD) begin
            old_d    = amoOldRaw;
            rdata_d  = amoRet;
            rvalid_d = 1'b1;
        end
    end

    // AMO context and response registers
    always_ff @(posedge i_riscv_dmem_clk or negedge i_riscv_dmem_rst_n) begin
        if (!i_riscv_dmem_rst_n) begin
            amoIdx_q    <= '0;
            amoLane_q   <= 1'b0;
            amoIsWord_q <= 1'b0;
            amoOp_q     <= AMO_SWAP;
            operand_q   <= '0;
            old_q       <= '0;
            rdata_q     <= '0;
            rvalid_q    <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            amoIdx_q    <= amoIdx_d;
            amoLane_q   <= amoLane_d;
            amoIsWord_q <= amoIsWord_d;
            amoOp_q     <= amoOp_d;
            operand_q   <= operand_d;
            old_q       <= old_d;
            rdata_q     <= rdata_d;
            rvalid_q    <= rvalid_d;
            fault_q     <= fault_d;
        end
    end

    assign bus.o_riscv_dmem_rdata  = rdata_q;
    assign bus.o_riscv_dmem_rvalid = rvalid_q;
    assign bus.o_riscv_dmem_stall  = stallComb;
    assign bus.o_riscv_dmem_fault  = fault_q;

endmodule

// File: tb/tb_riscv_dmem_resp.sv
// Scoreboard bench for riscv_dmem_resp against a byte-array reference memory.
module tb_riscv_dmem_resp;
    import riscv_pkg::*;

    localparam int DEPTH  = 64;
    localparam int ADDR_W = 6;
    localparam int NBYTES = DEPTH * 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    riscv_dmem_resp_if bus ();

    riscv_dmem_resp #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .i_riscv_dmem_clk   (clk),
        .i_riscv_dmem_rst_n (rst_n),
        .bus                (bus)
    );

    typedef struct {
        bit          isFault;
        logic [63:0] data;
        int          cycle;
    } exp_t;

    exp_t        expQ[$];
    int          testsRun  = 0;
    int          failCount = 0;
    int          cycCnt    = 0;
    logic [7:0]  refMem [NBYTES];

    // Cycle counter used to check response latency
    always @(posedge clk) cycCnt++;

    // Watchdog so the run always ends
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        testsRun++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%016h, required 0x%016h (cycle %0d)", name, act, exp, cycCnt);
        end
    endtask

    // Reference memory: flat little-endian bytes, address wrapped to the array size
    function automatic logic [63:0] refLoad(input logic [63:0] addr, input int n);
        logic [63:0] v = '0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = refMem[int'((addr + 64'(i)) % 64'(NBYTES))];
        return v;
    endfunction

    task automatic refStore(input logic [63:0] addr, input int n, input logic [63:0] v);
        for (int i = 0; i < n; i++) refMem[int'((addr + 64'(i)) % 64'(NBYTES))] = v[8*i +: 8];
    endtask

    function automatic logic [63:0] refAmo(input logic [3:0] op, input logic [63:0] old,
                                           input logic [63:0] opd, input int n);
        longint          sa, sb;
        longint unsigned ua, ub;
        sa = (n == 4) ? longint'(int'(old[31:0])) : longint'(old);
        sb = (n == 4) ? longint'(int'(opd[31:0])) : longint'(opd);
        ua = (n == 4) ? {32'b0, old[31:0]} : old;
        ub = (n == 4) ? {32'b0, opd[31:0]} : opd;
        case (op)
            4'd0:    return ub;
            4'd1:    return ua + ub;
            4'd2:    return ua ^ ub;
            4'd3:    return ua & ub;
            4'd4:    return ua | ub;
            4'd5:    return (sa < sb) ? sa : sb;
            4'd6:    return (sa > sb) ? sa : sb;
            4'd7:    return (ua < ub) ? ua : ub;
            default: return (ua > ub) ? ua : ub;
        endcase
    endfunction

    task automatic clearInputs();
        bus.i_riscv_dmem_memread_en  = 1'b0;
        bus.i_riscv_dmem_memwrite_en = 1'b0;
        bus.i_riscv_dmem_amo_en      = 1'b0;
        bus.i_riscv_dmem_amo_op      = 4'd0;
        bus.i_riscv_dmem_size        = 2'd0;
        bus.i_riscv_dmem_address     = '0;
        bus.i_riscv_dmem_wdata       = '0;
    endtask

    // Monitor: every presented response is popped from the scoreboard and checked
    task automatic handleOut(input bit isFault, input logic [63:0] data);
        exp_t e;
        if (expQ.size() == 0) begin
            testsRun++;
            failCount++;
            $display("[TB] FAIL unexpected_%s: got response 0x%016h, required none", isFault ? "fault" : "rvalid", data);
        end else begin
            e = expQ.pop_front();
            checkOutput("resp_kind_is_fault", 64'(isFault), 64'(e.isFault));
            checkOutput("resp_cycle", 64'(cycCnt), 64'(e.cycle));
            if (!e.isFault) checkOutput("rdata", data, e.data);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.o_riscv_dmem_rvalid === 1'b1) handleOut(1'b0, bus.o_riscv_dmem_rdata);
            if (bus.o_riscv_dmem_fault === 1'b1) handleOut(1'b1, 64'd0);
        end
    end

    // Issue one request starting just after a falling edge; returns one falling edge after the pipeline advances
    task automatic applyStimulus(input bit rd, input bit wr, input bit amo, input logic [3:0] op,
                                 input logic [1:0] size, input logic [63:0] addr, input logic [63:0] wdata);
        int          n;
        bit          isAmo, okAmo;
        logic [63:0] old, nv, ret;
        exp_t        e;
        n     = 1 << size;
        isAmo = rd && amo;
        okAmo = 1'b0;
        bus.i_riscv_dmem_memread_en  = rd;
        bus.i_riscv_dmem_memwrite_en = wr;
        bus.i_riscv_dmem_amo_en      = amo;
        bus.i_riscv_dmem_amo_op      = op;
        bus.i_riscv_dmem_size        = size;
        bus.i_riscv_dmem_address     = addr;
        bus.i_riscv_dmem_wdata       = wdata;
        if (rd || wr) begin
            if ((addr % 64'(n)) != 0 || (isAmo && n < 4)) begin
                e = '{isFault: 1'b1, data: 64'd0, cycle: cycCnt + 1};
                expQ.push_back(e);
            end else if (isAmo) begin
                okAmo = 1'b1;
                old = refLoad(addr, n);
                nv  = refAmo(op, old, wdata, n);
                refStore(addr, n, nv);
                ret = (n == 4) ? {{32{old[31]}}, old[31:0]} : old;
                e = '{isFault: 1'b0, data: ret, cycle: cycCnt + 2};
                expQ.push_back(e);
            end else if (wr) begin
                refStore(addr, n, wdata);
            end else begin
                e = '{isFault: 1'b0, data: refLoad(addr, n), cycle: cycCnt + 1};
                expQ.push_back(e);
            end
        end
        #1;
        checkOutput("stall_request_cycle", 64'(bus.o_riscv_dmem_stall), 64'(okAmo));
        @(posedge clk);
        @(negedge clk);
        if (okAmo) begin
            checkOutput("stall_amo_rd", 64'(bus.o_riscv_dmem_stall), 64'd1);
            @(posedge clk);
            @(negedge clk);
            checkOutput("stall_amo_wr", 64'(bus.o_riscv_dmem_stall), 64'd0);
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    initial begin
        logic [63:0] addr, preVal;
        logic [1:0]  sz;
        int          kind;
        exp_t        e;

        clearInputs();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset_rdata",  bus.o_riscv_dmem_rdata, 64'd0);
        checkOutput("reset_rvalid", 64'(bus.o_riscv_dmem_rvalid), 64'd0);
        checkOutput("reset_stall",  64'(bus.o_riscv_dmem_stall), 64'd0);
        checkOutput("reset_fault",  64'(bus.o_riscv_dmem_fault), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Fill the whole array so every later read has a defined value
        for (int i = 0; i < DEPTH; i++) applyStimulus(0, 1, 0, 4'd0, 2'd3, 64'(i * 8), {$urandom, $urandom});

        // Directed scenarios
        applyStimulus(0, 1, 0, 4'd0, 2'd3, 64'h40, 64'h1122334455667788);
        applyStimulus(1, 0, 0, 4'd0, 2'd3, 64'h40, 64'd0);
        applyStimulus(0, 1, 0, 4'd0, 2'd0, 64'h43, 64'hAA);
        applyStimulus(1, 0, 0, 4'd0, 2'd0, 64'h43, 64'd0);
        applyStimulus(1, 0, 0, 4'd0, 2'd3, 64'h40, 64'd0);
        applyStimulus(0, 1, 0, 4'd0, 2'd2, 64'h44, 64'hFFFFFFFF);
        applyStimulus(1, 0, 1, 4'd1, 2'd2, 64'h44, 64'd1);
        applyStimulus(1, 0, 0, 4'd0, 2'd3, 64'h40, 64'd0);
        applyStimulus(0, 1, 0, 4'd0, 2'd3, 64'h48, 64'd5);
        applyStimulus(1, 0, 1, 4'd5, 2'd3, 64'h48, -64'sd3);
        applyStimulus(1, 0, 0, 4'd0, 2'd3, 64'h48, 64'd0);
        applyStimulus(0, 1, 0, 4'd0, 2'd3, 64'h48, 64'd5);
        applyStimulus(1, 0, 1, 4'd7, 2'd3, 64'h48, -64'sd3);
        applyStimulus(1, 0, 0, 4'd0, 2'd3, 64'h48, 64'd0);
        applyStimulus(1, 0, 0, 4'd0, 2'd2, 64'h42, 64'd0);
        applyStimulus(0, 1, 0, 4'd0, 2'd2, 64'h42, 64'hDEADBEEF);
        applyStimulus(1, 0, 0, 4'd0, 2'd3, 64'h40, 64'd0);
        applyStimulus(1, 1, 0, 4'd0, 2'd1, 64'h46, 64'h5A5A);
        applyStimulus(1, 0, 1, 4'd0, 2'd0, 64'h50, 64'd9);
        applyStimulus(1, 0, 1, 4'd0, 2'd2, 64'h50, 64'h80000001);
        applyStimulus(1, 0, 1, 4'd4, 2'd3, 64'h58, 64'hF0F0F0F0F0F0F0F0);
        applyStimulus(1, 0, 1, 4'd6, 2'd2, 64'h54, 64'h7FFFFFFF);
        applyStimulus(1, 0, 0, 4'd0, 2'd3, 64'h50, 64'd0);
        applyStimulus(1, 0, 0, 4'd0, 2'd3, 64'h40 | (64'd1 << 20), 64'd0);

        // Reset during AMO_RD: nothing is written and the response never appears
        preVal = refLoad(64'h60, 8);
        bus.i_riscv_dmem_memread_en = 1'b1;
        bus.i_riscv_dmem_amo_en     = 1'b1;
        bus.i_riscv_dmem_amo_op     = 4'd1;
        bus.i_riscv_dmem_size       = 2'd3;
        bus.i_riscv_dmem_address    = 64'h60;
        bus.i_riscv_dmem_wdata      = 64'd7;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        clearInputs();
        #1;
        checkOutput("amo_reset_stall",  64'(bus.o_riscv_dmem_stall), 64'd0);
        checkOutput("amo_reset_rvalid", 64'(bus.o_riscv_dmem_rvalid), 64'd0);
        checkOutput("amo_reset_rdata",  bus.o_riscv_dmem_rdata, 64'd0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        applyStimulus(1, 0, 0, 4'd0, 2'd3, 64'h60, 64'd0);
        checkOutput("amo_reset_model_untouched", refLoad(64'h60, 8), preVal);

        // Randomised traffic including misalignment and aliasing high bits
        for (int i = 0; i < 300; i++) begin
            kind = $urandom_range(0, 3);
            sz   = 2'($urandom_range(0, 3));
            if (kind == 2 && $urandom_range(0, 7) != 0) sz = 2'($urandom_range(2, 3));
            addr = {$urandom, $urandom};
            if ($urandom_range(0, 7) != 0) addr = addr & ~((64'd1 << sz) - 64'd1);
            case (kind)
                0: applyStimulus(1, 0, 0, 4'd0, sz, addr, 64'd0);
                1: applyStimulus(0, 1, 0, 4'd0, sz, addr, {$urandom, $urandom});
                2: applyStimulus(1, 0, 1, 4'($urandom_range(0, 8)), sz, addr, {$urandom, $urandom});
                default: applyStimulus(1, 1, 0, 4'd0, sz, addr, {$urandom, $urandom});
            endcase
        end

        clearInputs();
        repeat (4) @(negedge clk);
        testsRun++;
        if (expQ.size() != 0) begin
            failCount++;
            e = expQ[0];
            $display("[TB] FAIL missing_responses: got %0d outstanding (first due cycle %0d), required 0", expQ.size(), e.cycle);
        end
        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
